// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the arbiter that sequences it.
//   F_*    : 3-bit ALU function codes (F_ILL is the one reserved code)
//   state_t: arbiter FSM states
//   WIDTH  : datapath width
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [2:0] F_AND  = 3'b000;
  localparam logic [2:0] F_OR   = 3'b001;
  localparam logic [2:0] F_ADD  = 3'b010;
  localparam logic [2:0] F_ILL  = 3'b011;
  localparam logic [2:0] F_ANDN = 3'b100;
  localparam logic [2:0] F_ORN  = 3'b101;
  localparam logic [2:0] F_SUB  = 3'b110;
  localparam logic [2:0] F_SLT  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU.
//   f    in  3      function code (see alu_pkg F_*)
//   a    in  WIDTH  operand a
//   b    in  WIDTH  operand b
//   y    out WIDTH  result (0 for the reserved code)
//   zero out 1      y == 0
module alu
  import alu_pkg::*;
(
  input  logic [2:0]       f,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             zero
);

  always_comb begin
    y = '0;
    case (f)
      F_AND:   y = a & b;
      F_OR:    y = a | b;
      F_ADD:   y = a + b;
      F_ANDN:  y = a & ~b;
      F_ORN:   y = a | ~b;
      F_SUB:   y = a - b;
      F_SLT:   y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters.
// Each accepted operation walks IDLE -> EXEC -> RESP; the response is held
// until the consumer takes it, and only then is a new request accepted.
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (NREQ bits)
//   req_f/req_a/req_b     packed per-requester function and operands
//   rsp_valid/rsp_ready   response handshake
//   rsp_id/y/zero/err     owner index, result, zero flag, illegal-code flag
//   busy                  FSM not in IDLE
//   op_count              completed responses, wraps at 16 bits
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [3*NREQ-1:0]     req_f,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_y,
  output logic                  rsp_zero,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [15:0]           op_count
);

  // Returns {found, index}: the first requester with valid set, searching
  // upward from p and wrapping at NREQ. Lower offsets overwrite higher ones.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v,
                                           input logic [IDW-1:0]  p);
    logic [IDW:0]     res;
    logic [IDW-1:0]   idx;
    logic [NREQ-1:0]  sh;
    int               j;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(p) + k;
      if (j >= NREQ) j = j - NREQ;
      idx = IDW'(j);
      sh  = v >> idx;
      if (sh[0]) res = {1'b1, idx};
    end
    return res;
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDW-1:0]     r_ptr;
  logic [IDW-1:0]     r_id;
  logic [2:0]         r_f;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_y;
  logic               r_zero;
  logic               r_err;
  logic [15:0]        r_cnt;

  logic [IDW:0]       w_pick;
  logic               w_found;
  logic [IDW-1:0]     w_win;
  logic [IDW-1:0]     w_ptr_nxt;
  logic               w_accept;
  logic [NREQ-1:0]    w_ready;
  logic [2:0]         w_sel_f;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;
  logic [WIDTH-1:0]   w_alu_y;
  logic               w_alu_zero;
  logic               w_ill;

  assign w_pick  = rr_pick(req_valid, r_ptr);
  assign w_found = w_pick[IDW];
  assign w_win   = w_pick[IDW-1:0];

  assign w_ptr_nxt = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);

  // Operand mux for the winning requester
  assign w_sel_f = 3'(req_f >> (3 * int'(w_win)));
  assign w_sel_a = WIDTH'(req_a >> (WIDTH * int'(w_win)));
  assign w_sel_b = WIDTH'(req_b >> (WIDTH * int'(w_win)));

  // Grant is combinational in IDLE; suppressed while reset is high so no
  // requester believes it was accepted in a cycle the FSM ignores.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found && !reset) begin
          w_ready     = NREQ'(1) << w_win;
          w_accept    = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC:    w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---- accept stage: operand capture (data only, no reset needed) ----
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_f <= w_sel_f;
      r_a <= w_sel_a;
      r_b <= w_sel_b;
    end
  end

  // ---- execute stage: the shared ALU runs from the operand registers ----
  alu u_alu (
    .f    (r_f),
    .a    (r_a),
    .b    (r_b),
    .y    (w_alu_y),
    .zero (w_alu_zero)
  );

  assign w_ill = (r_f == F_ILL);

  // ---- response stage: control, result hold and completion count ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_y     <= '0;
      r_zero  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_id  <= w_win;
        r_ptr <= w_ptr_nxt;
      end
      if (r_state == EXEC) begin
        // The reserved code reports a forced zero result with the error flag
        r_y    <= w_ill ? '0 : w_alu_y;
        r_zero <= w_ill ? 1'b1 : w_alu_zero;
        r_err  <= w_ill;
      end
      if (r_state == RESP && rsp_ready) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign req_ready = w_ready;
  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_id;
  assign rsp_y     = r_y;
  assign rsp_zero  = r_zero;
  assign rsp_err   = r_err;
  assign busy      = (r_state != IDLE);
  assign op_count  = r_cnt;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with two requesters.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_f;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [0:0]        rsp_id;
  logic [31:0]       rsp_y;
  logic              rsp_zero;
  logic              rsp_err;
  logic              busy;
  logic [15:0]       op_count;

  int n_run  = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  alu_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_f     (req_f),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input logic idx, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b);
    if (idx == 1'b0) begin
      req_f[2:0] = f;  req_a[31:0] = a;  req_b[31:0] = b;
    end else begin
      req_f[5:3] = f;  req_a[63:32] = a; req_b[63:32] = b;
    end
  endtask

  // Raise valid, wait for the grant, then count cycles until rsp_valid.
  task automatic issue(input logic idx, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b, output int lat);
    int k;
    set_op(idx, f, a, b);
    req_valid[idx] = 1'b1;
    #1;
    k = 0;
    while (!req_ready[idx] && k < 20) begin
      step();
      k++;
    end
    if (!req_ready[idx]) begin
      check("grant_timeout", 32'd0, 32'd1);
      req_valid[idx] = 1'b0;
      lat = -1;
      return;
    end
    check("grant_onehot", 32'(req_ready), idx ? 32'd2 : 32'd1);
    step();
    req_valid[idx] = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic expect_rsp(input string tag, input logic id, input logic [31:0] y,
                            input logic z, input logic e);
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_id"},    32'(rsp_id),    32'(id));
    check({tag, "_y"},     rsp_y,          y);
    check({tag, "_zero"},  32'(rsp_zero),  32'(z));
    check({tag, "_err"},   32'(rsp_err),   32'(e));
  endtask

  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    step();
    exp_cnt++;
    check({tag, "_drop"},  32'(rsp_valid), 32'd0);
    check({tag, "_count"}, 32'(op_count),  32'(exp_cnt));
  endtask

  int lat;
  int grants[8];
  int ng;
  logic last_grant;

  initial begin
    reset = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 1'b0;
    req_f = '0; req_a = '0; req_b = '0;
    step();
    step();
    // reset state
    check("rst_ready",  32'(req_ready), 32'd0);
    check("rst_valid",  32'(rsp_valid), 32'd0);
    check("rst_busy",   32'(busy),      32'd0);
    check("rst_count",  32'(op_count),  32'd0);
    check("rst_y",      rsp_y,          32'd0);
    check("rst_id",     32'(rsp_id),    32'd0);
    check("rst_zero",   32'(rsp_zero),  32'd0);
    check("rst_err",    32'(rsp_err),   32'd0);
    req_valid = 2'b00;
    reset = 1'b0;
    step();

    // single ADD op and latency
    rsp_ready = 1'b1;
    issue(1'b0, F_ADD, 32'd5, 32'd3, lat);
    check("add_latency", 32'(lat), 32'd2);
    check("add_busy", 32'(busy), 32'd1);
    expect_rsp("add", 1'b0, 32'd8, 1'b0, 1'b0);
    check("add_count_pre", 32'(op_count), 32'd0);
    consume("add");

    // SUB equal operands from req1, then SLT signed from req0
    issue(1'b1, F_SUB, 32'h0000_1234, 32'h0000_1234, lat);
    expect_rsp("sub", 1'b1, 32'd0, 1'b1, 1'b0);
    consume("sub");
    issue(1'b0, F_SLT, 32'hFFFF_FFFF, 32'd1, lat);
    expect_rsp("slt", 1'b0, 32'd1, 1'b0, 1'b0);
    consume("slt");

    // round-robin with both requesters valid from reset
    reset = 1'b1;
    req_valid = 2'b11;
    set_op(1'b0, F_ADD, 32'd1, 32'd1);
    set_op(1'b1, F_ADD, 32'd2, 32'd2);
    step();
    check("rr_rst_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    exp_cnt = 0;
    ng = 0;
    last_grant = 1'b0;
    #1;
    for (int i = 0; i < 12; i++) begin
      if (req_ready != 2'b00) begin
        check("rr_onehot", 32'(req_ready == 2'b11), 32'd0);
        last_grant = req_ready[1];
        if (ng < 8) grants[ng] = int'(req_ready[1]);
        ng++;
      end
      if (rsp_valid) begin
        check("rr_id", 32'(rsp_id), 32'(last_grant));
        check("rr_y", rsp_y, last_grant ? 32'd4 : 32'd2);
        exp_cnt++;
      end
      step();
    end
    req_valid = 2'b00;
    check("rr_ngrants", 32'(ng), 32'd4);
    check("rr_g0", 32'(grants[0]), 32'd0);
    check("rr_g1", 32'(grants[1]), 32'd1);
    check("rr_g2", 32'(grants[2]), 32'd0);
    check("rr_g3", 32'(grants[3]), 32'd1);
    check("rr_count", 32'(op_count), 32'd4);

    // backpressure: response held for 4 cycles while req0 waits
    rsp_ready = 1'b0;
    issue(1'b1, F_OR, 32'h0000_00F0, 32'h0000_000F, lat);
    expect_rsp("bp", 1'b1, 32'h0000_00FF, 1'b0, 1'b0);
    req_valid = 2'b01;
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_y", rsp_y, 32'h0000_00FF);
      check("bp_hold_id", 32'(rsp_id), 32'd1);
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_count", 32'(op_count), 32'(exp_cnt));
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_count_pre", 32'(op_count), 32'(exp_cnt));
    consume("bp");
    check("bp_next_grant", 32'(req_ready), 32'd1);
    req_valid = 2'b00;
    #1;

    // illegal code, then legal ops clear the error flag
    issue(1'b0, F_ILL, 32'd7, 32'd9, lat);
    expect_rsp("ill", 1'b0, 32'd0, 1'b1, 1'b1);
    consume("ill");
    issue(1'b1, F_ANDN, 32'h0000_00FF, 32'h0000_000F, lat);
    expect_rsp("andn", 1'b1, 32'h0000_00F0, 1'b0, 1'b0);
    consume("andn");
    issue(1'b0, F_ORN, 32'h0000_0000, 32'hFFFF_FFF0, lat);
    expect_rsp("orn", 1'b0, 32'h0000_000F, 1'b0, 1'b0);
    consume("orn");
    issue(1'b1, F_AND, 32'hF0F0_F0F0, 32'h0F0F_0F0F, lat);
    expect_rsp("and", 1'b1, 32'd0, 1'b1, 1'b0);
    consume("and");

    // reset while in EXEC discards the op and rewinds ptr
    set_op(1'b0, F_ADD, 32'd1, 32'd1);
    req_valid = 2'b01;
    #1;
    check("mid_grant", 32'(req_ready), 32'd1);
    step();
    req_valid = 2'b00;
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_cnt = 0;
    #1;
    check("mid_count", 32'(op_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("mid_no_rsp", 32'(rsp_valid), 32'd0);
      step();
    end
    req_valid = 2'b11;
    set_op(1'b1, F_ADD, 32'd3, 32'd3);
    #1;
    check("mid_rr_grant", 32'(req_ready), 32'd1);
    step();
    req_valid = 2'b00;
    step();
    expect_rsp("mid", 1'b0, 32'd2, 1'b0, 1'b0);
    consume("mid");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
